// File: rtl/darkriscv_muldiv_seq_if.sv
// Request/response bundle between the darkriscv core and the iterative multiply/divide sequencer.
// The core drives the master side and the sequencer takes the slave side.
interface darkriscv_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [4:0]      rdIn;
    logic            halt;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] wData;
    logic [4:0]      wAddr;
    logic            ill;

    modport master (
        output req, funct3, rs1Data, rs2Data, rdIn,
        input  halt, busy, done, wData, wAddr, ill
    );

    modport slave (
        input  req, funct3, rs1Data, rs2Data, rdIn,
        output halt, busy, done, wData, wAddr, ill
    );
endinterface

// File: rtl/darkriscv_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide, one result per op.
// Define MULDIV_DIV_EN to build the divider; without it, FUNCT3[2]=1 requests pulse ILL instead.
module darkriscv_muldiv_seq #(
    parameter int XLEN = 32
) (
    input logic                    clk_i,
    input logic                    rst_i,
    darkriscv_muldiv_seq_if.slave  md
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [2:0] {IDLE, SETUP, RUN, FIX, DONE} state_t;

    state_t            state_q;
    logic [2:0]        funct3_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   opA_q;
    logic [XLEN-1:0]   opB_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_d;
    logic [CW-1:0]     count_q;
    logic              negLo_q;
    logic              fixPhase_q;
    logic [XLEN-1:0]   wdata_q;
    logic [4:0]        waddr_q;
    logic              busy_q;
    logic              done_q;
    logic              ill_q;
    logic              accept;
    logic              aNeg;
    logic              bNeg;
    logic [XLEN:0]     mulSum;

`ifdef MULDIV_DIV_EN
    logic              negHi_q;
    logic [XLEN:0]     remShift;
    logic [XLEN-1:0]   remSub;
    logic              remGeq;
    assign accept = md.req;
`else
    assign accept = md.req & ~md.funct3[2];
`endif

    assign md.halt  = (accept && state_q == IDLE) || (state_q != IDLE && state_q != DONE);
    assign md.busy  = busy_q;
    assign md.done  = done_q;
    assign md.wData = wdata_q;
    assign md.wAddr = waddr_q;
    assign md.ill   = ill_q;

    // rs1 is signed for MULH/MULHSU/DIV/REM, rs2 only for MULH/DIV/REM.
    assign aNeg = opA_q[XLEN-1] & ((funct3_q == 3'd1) | (funct3_q == 3'd2) |
                                   (funct3_q == 3'd4) | (funct3_q == 3'd6));
    assign bNeg = opB_q[XLEN-1] & ((funct3_q == 3'd1) | (funct3_q == 3'd4) | (funct3_q == 3'd6));

    // Multiply keeps the partial product in the upper half and the shrinking multiplier in the lower
    // half; divide keeps the partial remainder in the upper half and shifts quotient bits into the lower.
    always_comb begin
        mulSum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opB_q};
        acc_d  = acc_q[0] ? {mulSum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        remShift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        remGeq   = remShift >= {1'b0, opB_q};
        remSub   = remShift[XLEN-1:0] - opB_q;
        if (funct3_q[2]) begin
            acc_d = remGeq ? {remSub, acc_q[XLEN-2:0], 1'b1}
                           : {remShift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            funct3_q   <= '0;
            rd_q       <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            negLo_q    <= 1'b0;
            fixPhase_q <= 1'b0;
            wdata_q    <= '0;
            waddr_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ill_q      <= 1'b0;
`ifdef MULDIV_DIV_EN
            negHi_q    <= 1'b0;
`endif
        end else begin
            ill_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        funct3_q <= md.funct3;
                        opA_q    <= md.rs1Data;
                        opB_q    <= md.rs2Data;
                        rd_q     <= md.rdIn;
                        busy_q   <= 1'b1;
                        state_q  <= SETUP;
                    end else if (md.req) begin
                        ill_q <= 1'b1;
                    end
                end
                SETUP: begin
                    acc_q      <= {{XLEN{1'b0}}, aNeg ? -opA_q : opA_q};
                    opB_q      <= bNeg ? -opB_q : opB_q;
                    negLo_q    <= aNeg ^ bNeg;
                    count_q    <= CNT_LAST;
                    fixPhase_q <= 1'b0;
                    state_q    <= RUN;
`ifdef MULDIV_DIV_EN
                    negHi_q <= aNeg;
                    // Specials bypass the loop with the architecturally defined results preloaded.
                    if (funct3_q[2] && opB_q == '0) begin
                        acc_q   <= {opA_q, {XLEN{1'b1}}};
                        negLo_q <= 1'b0;
                        negHi_q <= 1'b0;
                        state_q <= FIX;
                    end else if (funct3_q[2] && !funct3_q[0] && opA_q == {1'b1, {(XLEN-1){1'b0}}}
                                 && opB_q == {XLEN{1'b1}}) begin
                        acc_q   <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                        negLo_q <= 1'b0;
                        negHi_q <= 1'b0;
                        state_q <= FIX;
                    end
`endif
                end
                RUN: begin
                    acc_q   <= acc_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    // First cycle applies the sign correction, second picks the half and registers it.
                    if (!fixPhase_q) begin
                        fixPhase_q <= 1'b1;
`ifdef MULDIV_DIV_EN
                        if (funct3_q[2]) begin
                            acc_q <= {negHi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN],
                                      negLo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]};
                        end else begin
                            acc_q <= negLo_q ? -acc_q : acc_q;
                        end
`else
                        acc_q <= negLo_q ? -acc_q : acc_q;
`endif
                    end else begin
                        fixPhase_q <= 1'b0;
                        if (funct3_q == 3'd0 || (funct3_q[2] && !funct3_q[1])) begin
                            wdata_q <= acc_q[XLEN-1:0];
                        end else begin
                            wdata_q <= acc_q[2*XLEN-1:XLEN];
                        end
                        waddr_q <= rd_q;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_darkriscv_muldiv_seq.sv
// Scoreboard bench for darkriscv_muldiv_seq: directed ops push expected results, a negedge monitor
// pops and compares result, destination and completion cycle whenever DONE pulses.
module tb_darkriscv_muldiv_seq;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        int          cycle;
        string       name;
    } expect_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    int      cycleCnt = 0;
    int      checks = 0;
    int      errors = 0;
    expect_t scoreboard[$];

    darkriscv_muldiv_seq_if #(.XLEN(32)) mdIf ();

    darkriscv_muldiv_seq #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .md    (mdIf.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt = cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        expect_t e;
        if (mdIf.done === 1'b1) begin
            if (scoreboard.size() == 0) begin
                checkOutput("unexpectedDone", 64'd1, 64'd0);
            end else begin
                e = scoreboard.pop_front();
                checkOutput({e.name, ".wdata"}, 64'(mdIf.wData), 64'(e.data));
                checkOutput({e.name, ".waddr"}, 64'(mdIf.wAddr), 64'(e.addr));
                checkOutput({e.name, ".cycle"}, 64'(cycleCnt), 64'(e.cycle));
            end
        end
`ifdef MULDIV_DIV_EN
        if (mdIf.ill === 1'b1) checkOutput("unexpectedIll", 64'd1, 64'd0);
`endif
    end

    // Drives one request cycle; lat=0 means no result is expected.
    task automatic applyStimulus(input string name, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input logic [31:0] expData, input int lat, input logic expHalt);
        expect_t e;
        @(negedge clk);
        mdIf.req     = 1'b1;
        mdIf.funct3  = f3;
        mdIf.rs1Data = a;
        mdIf.rs2Data = b;
        mdIf.rdIn    = rd;
        #1;
        checkOutput({name, ".haltReq"}, 64'(mdIf.halt), 64'(expHalt));
        if (lat > 0) begin
            e.data  = expData;
            e.addr  = rd;
            e.cycle = cycleCnt + 1 + lat;
            e.name  = name;
            scoreboard.push_back(e);
        end
        @(negedge clk);
        mdIf.req = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 100 && (scoreboard.size() != 0 || mdIf.busy !== 1'b0); i++) begin
            @(negedge clk);
        end
        checkOutput({name, ".drain"}, 64'(scoreboard.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycleCnt);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic haltOk;
        mdIf.req     = 1'b0;
        mdIf.funct3  = 3'd0;
        mdIf.rs1Data = 32'd0;
        mdIf.rs2Data = 32'd0;
        mdIf.rdIn    = 5'd0;

        repeat (3) @(negedge clk);
        checkOutput("reset.busy", 64'(mdIf.busy), 64'd0);
        checkOutput("reset.done", 64'(mdIf.done), 64'd0);
        checkOutput("reset.ill", 64'(mdIf.ill), 64'd0);
        checkOutput("reset.wdata", 64'(mdIf.wData), 64'd0);
        checkOutput("reset.waddr", 64'(mdIf.wAddr), 64'd0);
        checkOutput("reset.halt", 64'(mdIf.halt), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // MUL 7*6 with a cycle-by-cycle look at HALT through the whole op.
        applyStimulus("mul7x6", 3'd0, 32'd7, 32'd6, 5'd5, 32'd42, 35, 1'b1);
        haltOk = 1'b1;
        for (int k = 0; k < 35; k++) begin
            if (k > 0) @(negedge clk);
            if (mdIf.halt !== 1'b1) haltOk = 1'b0;
        end
        checkOutput("mul7x6.haltRun", 64'(haltOk), 64'd1);
        @(negedge clk);
        checkOutput("mul7x6.haltDone", 64'(mdIf.halt), 64'd0);
        checkOutput("mul7x6.donePulse", 64'(mdIf.done), 64'd1);
        waitDrain("mul7x6");

        applyStimulus("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 35, 1'b1);
        waitDrain("mulh");
        applyStimulus("mulhuX0", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFE, 35, 1'b1);
        waitDrain("mulhuX0");
        applyStimulus("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd31, 32'hFFFF_FFFF, 35, 1'b1);
        waitDrain("mulhsu");
        applyStimulus("mulNeg", 3'd0, 32'hFFFF_FFFD, 32'd5, 5'd7, 32'hFFFF_FFF1, 35, 1'b1);
        waitDrain("mulNeg");

        // Reset in the middle of a multiply: the op is dropped without a DONE pulse.
        applyStimulus("mulAbort", 3'd0, 32'd11, 32'd13, 5'd4, 32'd143, 35, 1'b1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        scoreboard.delete();
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort.busy", 64'(mdIf.busy), 64'd0);
        checkOutput("abort.halt", 64'(mdIf.halt), 64'd0);
        repeat (40) @(negedge clk);
        applyStimulus("mulAfterAbort", 3'd0, 32'd11, 32'd13, 5'd4, 32'd143, 35, 1'b1);
        waitDrain("mulAfterAbort");

`ifdef MULDIV_DIV_EN
        applyStimulus("divOvf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h8000_0000, 3, 1'b1);
        waitDrain("divOvf");
        applyStimulus("remOvf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, 3, 1'b1);
        waitDrain("remOvf");
        applyStimulus("divuZero", 3'd5, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 3, 1'b1);
        waitDrain("divuZero");
        applyStimulus("remuZero", 3'd7, 32'd7, 32'd0, 5'd9, 32'd7, 3, 1'b1);
        waitDrain("remuZero");
        applyStimulus("remNeg", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 35, 1'b1);
        waitDrain("remNeg");
        applyStimulus("divNeg", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFD, 35, 1'b1);
        waitDrain("divNeg");
        applyStimulus("divu100by7", 3'd5, 32'd100, 32'd7, 5'd12, 32'd14, 35, 1'b1);
        waitDrain("divu100by7");
`else
        applyStimulus("divIll", 3'd4, 32'd10, 32'd2, 5'd3, 32'd0, 0, 1'b0);
        checkOutput("divIll.ill", 64'(mdIf.ill), 64'd1);
        checkOutput("divIll.busy", 64'(mdIf.busy), 64'd0);
        @(negedge clk);
        checkOutput("divIll.illDrop", 64'(mdIf.ill), 64'd0);
        repeat (40) @(negedge clk);
`endif

        applyStimulus("mul3x3", 3'd0, 32'd3, 32'd3, 5'd6, 32'd9, 35, 1'b1);
        waitDrain("mul3x3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
